// File: rtl/wb_master_arb.sv
// Two-master Wishbone arbiter: whole-cycle grants, round-robin on contention,
// and a stall watchdog that turns a hung slave access into a bus error.
module wb_master_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  localparam bit          WDOG_EN   = (TIMEOUT != 0);

  state_t      state, state_next;
  logic        last, last_next;   // index of the master granted most recently
  logic [15:0] stall;
  logic        tmo;
  logic        gnt0, gnt1;
  logic        gnt_stb;
  logic        stall_inc;
  logic        stall_clr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a variable unassigned (no latches).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_next = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_next = m0_cyc_i ? GNT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    last_next = last;
    if (state_next == GNT0)      last_next = 1'b0;
    else if (state_next == GNT1) last_next = 1'b1;
  end

  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign gnt_o   = {gnt1, gnt0};
  assign gnt_stb = gnt1 ? m1_stb_i : m0_stb_i;

  // Address/data path defaults to master 0 whenever master 1 is not granted.
  assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
  assign s_cyc_o = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
  assign s_stb_o = (gnt0 | gnt1) & gnt_stb & ~tmo;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | tmo);
  assign m1_err_o = gnt1 & (s_err_i | tmo);

  // Watchdog: counts consecutive unanswered strobes of the granted master.
  assign tmo       = WDOG_EN && (stall == TMO_LIMIT);
  assign stall_inc = s_cyc_o & gnt_stb & ~s_ack_i & ~s_err_i;
  assign stall_clr = ~stall_inc | tmo | (state_next != state);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         stall <= '0;
    else if (stall_clr) stall <= '0;
    else                stall <= stall + 16'd1;
  end

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed self-checking bench for wb_master_arb: grant latency, round-robin,
// atomicity, error passthrough, watchdog timing and asynchronous reset.
module tb_wb_master_arb;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  gnt_o;

  logic [31:0] m0_dat_z, m1_dat_z, s_adr_z, s_dat_z;
  logic        m0_ack_z, m0_err_z, m1_ack_z, m1_err_z;
  logic [3:0]  s_sel_z;
  logic        s_we_z, s_cyc_z, s_stb_z;
  logic [1:0]  gnt_z;

  int n_assert = 0;
  int n_fail   = 0;

  // Packed status: gnt[7:6] cyc[5] stb[4] m0_ack[3] m1_ack[2] m0_err[1] m1_err[0]
  wire [7:0] st = {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};

  always #5 clk = ~clk;

  wb_master_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  // Same stimulus, watchdog disabled.
  wb_master_arb #(.TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst_b(rst_b),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_z), .m0_ack_o(m0_ack_z),
    .m0_err_o(m0_err_z),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_z), .m1_ack_o(m1_ack_z),
    .m1_err_o(m1_err_z),
    .s_adr_o(s_adr_z), .s_dat_o(s_dat_z), .s_sel_o(s_sel_z), .s_we_o(s_we_z),
    .s_cyc_o(s_cyc_z), .s_stb_o(s_stb_z), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(gnt_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    m0_adr_i = 32'h1234_5678; m0_dat_i = 32'h0BAD_F00D; m0_sel_i = 4'hA; m0_we_i = 1'b1;
    m1_adr_i = 32'h8765_4321; m1_dat_i = 32'h1111_2222; m1_sel_i = 4'h5; m1_we_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s_dat_i = 32'hCAFE_F00D; s_ack_i = 1'b1; s_err_i = 1'b1;
    repeat (2) sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %b expected %b", st, 8'h00); end
    n_assert++; if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {32'h1234_5678, 32'h0BAD_F00D, 4'hA, 1'b1}) begin
      n_fail++; $display("FAIL reset_m0_path: got adr=%h dat=%h sel=%h we=%b", s_adr_o, s_dat_o, s_sel_o, s_we_o); end
    n_assert++; if ({m0_dat_o, m1_dat_o} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected cafef00d", m0_dat_o, m1_dat_o); end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0; m0_we_i = 1'b0;
    rst_b = 1'b1;
  endtask

  task automatic test_single_master();
    int acks = 0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
    sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL single_latency: got %b expected %b", st, 8'h00); end
    for (int i = 0; i < 4; i++) begin
      tick(); s_ack_i = 1'b0;
      sample();
      n_assert++; if (st !== 8'b0111_0000) begin n_fail++; $display("FAIL single_wait%0d: got %b expected %b", i, st, 8'b0111_0000); end
      tick(); s_ack_i = 1'b1; s_dat_i = 32'hD000_0000 + i;
      sample();
      if (m0_ack_o === 1'b1) acks++;
      n_assert++; if (st !== 8'b0111_1000) begin n_fail++; $display("FAIL single_ack%0d: got %b expected %b", i, st, 8'b0111_1000); end
      n_assert++; if (m0_dat_o !== 32'hD000_0000 + i) begin n_fail++; $display("FAIL single_rdata%0d: got %h expected %h", i, m0_dat_o, 32'hD000_0000 + i); end
    end
    n_assert++; if (acks !== 4) begin n_fail++; $display("FAIL single_ack_count: got %0d expected 4", acks); end
    tick(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    n_assert++; if (st !== 8'b0100_0000) begin n_fail++; $display("FAIL single_release: got %b expected %b", st, 8'b0100_0000); end
    tick(); sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL single_idle: got %b expected %b", st, 8'h00); end
  endtask

  task automatic test_contention();
    do_reset();
    // First contention after reset goes to m0, then hands straight to m1.
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    m0_adr_i = 32'h0000_00A0; m1_adr_i = 32'h0000_00B0;
    sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL cont_latency: got %b expected %b", st, 8'h00); end
    tick(); s_ack_i = 1'b1;
    sample();
    n_assert++; if ({st, s_adr_o} !== {8'b0111_1000, 32'h0000_00A0}) begin n_fail++; $display("FAIL cont_gnt0: got %b %h expected 01111000 000000a0", st, s_adr_o); end
    tick(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    n_assert++; if (st !== 8'b0100_0000) begin n_fail++; $display("FAIL cont_release0: got %b expected %b", st, 8'b0100_0000); end
    tick(); sample();
    n_assert++; if ({st, s_adr_o} !== {8'b1011_0000, 32'h0000_00B0}) begin n_fail++; $display("FAIL cont_handoff: got %b %h expected 10110000 000000b0", st, s_adr_o); end
    tick(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    sample();
    n_assert++; if (st !== 8'b1000_0000) begin n_fail++; $display("FAIL cont_release1: got %b expected %b", st, 8'b1000_0000); end
    tick(); sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL cont_idle: got %b expected %b", st, 8'h00); end
    // m1 was last: next contention goes to m0; m1 then withdraws unserved.
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); sample();
    n_assert++; if (st !== 8'b0111_0000) begin n_fail++; $display("FAIL cont_second: got %b expected %b", st, 8'b0111_0000); end
    tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL cont_idle2: got %b expected %b", st, 8'h00); end
    // m0 was last: m1 wins this one.
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); sample();
    n_assert++; if ({st, s_adr_o} !== {8'b1011_0000, 32'h0000_00B0}) begin n_fail++; $display("FAIL cont_third: got %b %h expected 10110000 000000b0", st, s_adr_o); end
  endtask

  task automatic test_atomic();
    m0_adr_i = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      tick(); m1_adr_i = 32'h0000_0200 + 32'(4 * i); s_ack_i = 1'b1;
      sample();
      n_assert++; if ({st, s_adr_o} !== {8'b1011_0100, 32'h0000_0200 + 32'(4 * i)}) begin
        n_fail++; $display("FAIL atomic_m1_%0d: got %b %h expected 10110100 %h", i, st, s_adr_o, 32'h0000_0200 + 32'(4 * i)); end
    end
    tick(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    sample();
    n_assert++; if (st !== 8'b1000_0000) begin n_fail++; $display("FAIL atomic_release: got %b expected %b", st, 8'b1000_0000); end
    tick(); sample();
    n_assert++; if ({st, s_adr_o} !== {8'b0111_0000, 32'h0000_0300}) begin n_fail++; $display("FAIL atomic_m0: got %b %h expected 01110000 00000300", st, s_adr_o); end
  endtask

  task automatic test_slave_err();
    tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h0100_0004; m1_dat_i = 32'h55AA_33CC;
    sample();
    n_assert++; if (st !== 8'b0100_0000) begin n_fail++; $display("FAIL err_handoff: got %b expected %b", st, 8'b0100_0000); end
    tick(); s_err_i = 1'b1;
    sample();
    n_assert++; if (st !== 8'b1011_0001) begin n_fail++; $display("FAIL err_pass: got %b expected %b", st, 8'b1011_0001); end
    n_assert++; if ({s_we_o, s_adr_o, s_dat_o} !== {1'b1, 32'h0100_0004, 32'h55AA_33CC}) begin
      n_fail++; $display("FAIL err_write_path: got we=%b adr=%h dat=%h", s_we_o, s_adr_o, s_dat_o); end
    tick(); s_err_i = 1'b0;
    sample();
    n_assert++; if (st !== 8'b1011_0000) begin n_fail++; $display("FAIL err_clear: got %b expected %b", st, 8'b1011_0000); end
  endtask

  task automatic test_async_reset();
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_we_i = 1'b0; s_ack_i = 1'b1;
    sample();
    n_assert++; if (st !== 8'b1011_0100) begin n_fail++; $display("FAIL arst_before: got %b expected %b", st, 8'b1011_0100); end
    #2 rst_b = 1'b0;
    #1;
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL arst_immediate: got %b expected %b", st, 8'h00); end
    s_ack_i = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    tick(); sample();
    n_assert++; if (st !== 8'b0111_0000) begin n_fail++; $display("FAIL arst_regrant: got %b expected %b", st, 8'b0111_0000); end
    tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); tick(); sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL arst_idle: got %b expected %b", st, 8'h00); end
  endtask

  task automatic test_watchdog();
    logic       e;
    logic [7:0] exp_st;
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0400;
    // c = 0 is the first stalled strobe; errors at c = 8 and, after restart, c = 17.
    for (int c = 0; c <= 20; c++) begin
      tick(); sample();
      e = (c == 8) || (c == 17);
      exp_st = {2'b01, 1'b1, ~e, 2'b00, e, 1'b0};
      n_assert++; if (st !== exp_st) begin n_fail++; $display("FAIL wdog_c%0d: got %b expected %b", c, st, exp_st); end
    end
    for (int c = 21; c < 1021; c++) begin
      tick(); sample();
      n_assert++; if ({m0_err_z, s_stb_z, m1_err_z} !== 3'b010) begin
        n_fail++; $display("FAIL wdog_disabled_c%0d: got err=%b stb=%b expected err=0 stb=1", c, m0_err_z, s_stb_z); end
    end
    tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick(); sample();
    n_assert++; if (st !== 8'h00) begin n_fail++; $display("FAIL wdog_idle: got %b expected %b", st, 8'h00); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit exceeded");
  end

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_atomic();
    test_slave_err();
    test_async_reset();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
